// File: rtl/list_pkg.sv
// Shared definitions for the list packer and the list cache: header layout,
// line geometry helpers and the per-line state record.
package list_pkg;

    // Header word layout (word 0 of every beat)
    localparam int unsigned HDR_TOGGLE_BIT = 0;
    localparam int unsigned HDR_COUNT_LSB  = 8;

    // Ceiling log2, returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Words per beat, header word included
    function automatic int unsigned frame_size(input int unsigned dw, input int unsigned dbw);
        return dbw / dw;
    endfunction

    // State recorded when a line buffer closes; count fits 8 bits since FS <= 256
    typedef struct packed {
        logic [7:0] count;
        logic       last;
    } line_state_t;

endpackage

// File: rtl/list_line_buf.sv
// One FS x DW line buffer: payload words 1..FS-1, write index, full flag,
// closing count/last record, and a read-out with the header word inserted.
module list_line_buf
    import list_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned FS = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_data,
    input  logic             wr_last,
    input  logic             flush,
    input  logic             clear,
    input  logic             toggle,
    output logic             full,
    output logic             last,
    output logic             closing,
    output logic [FS*DW-1:0] rd_data
);

    localparam int unsigned CW = clog2(FS);

    logic [DW-1:0] mem [1:FS-1];
    logic [CW-1:0] idx_q;
    logic          full_q;
    line_state_t   st_q;

    // Close on the element filling the last word, on I_LAST, or on an idle flush
    assign closing = (wr_en && (wr_last || (idx_q == CW'(FS - 1)))) || flush;
    assign full    = full_q;
    assign last    = st_q.last;

    // Payload storage; unwritten words are masked at read-out so no reset is needed
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[idx_q] <= wr_data;
        end
    end

    // Write index, full flag and close record
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            full_q <= 1'b0;
            idx_q  <= CW'(1);
            st_q   <= '0;
        end else if (clear) begin
            full_q <= 1'b0;
            idx_q  <= CW'(1);
        end else if (wr_en) begin
            if (closing) begin
                full_q     <= 1'b1;
                st_q.count <= 8'(idx_q);
                st_q.last  <= wr_last;
                idx_q      <= CW'(1);
            end else begin
                idx_q <= idx_q + CW'(1);
            end
        end else if (flush) begin
            full_q     <= 1'b1;
            st_q.count <= 8'(idx_q - CW'(1));
            st_q.last  <= 1'b0;
            idx_q      <= CW'(1);
        end
    end

    // Beat image: header in word 0, payload up to count, zeros elsewhere and when empty
    always_comb begin
        rd_data = '0;
        if (full_q) begin
            rd_data[HDR_TOGGLE_BIT]         = toggle;
            rd_data[HDR_COUNT_LSB +: CW]    = st_q.count[CW-1:0];
            for (int unsigned k = 1; k < FS; k++) begin
                if (k <= 32'(st_q.count)) begin
                    rd_data[k*DW +: DW] = mem[k];
                end
            end
        end
    end

endmodule

// File: rtl/list_packer.sv
// Packs DW-bit list elements into DBW-bit AXI4-Stream beats using two ping-pong
// line buffers. Word 0 of each beat is a header (sequence toggle + count).
// Optional idle flush of partial lines: define LIST_PACKER_TIMEOUT_EN.
module list_packer
    import list_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned DBW     = 4096,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    input  logic [DW-1:0]  IN,
    input  logic           I_VALID,
    input  logic           I_LAST,
    output logic           O_READY,
    output logic [DBW-1:0] TDATA,
    output logic           TVALID,
    input  logic           TREADY,
    output logic           TLAST,
    output logic [3:0]     TDEST,
    output logic [7:0]     TID
);

    localparam int unsigned FS = frame_size(DW, DBW);

    logic           init_q;
    logic           fill_ptr;
    logic           drain_ptr;
    logic           toggle_q;
    logic [1:0]     full;
    logic [1:0]     last;
    logic [1:0]     closing;
    logic [1:0]     wr_en;
    logic [1:0]     clear;
    logic [1:0]     flush;
    logic [FS*DW-1:0] rd_data [2];
    logic           accept;
    logic           close;
    logic           hs;
    logic           force_close;

    // O_READY derives only from flops, so TREADY never reaches it combinationally
    assign O_READY = init_q && !full[fill_ptr];
    assign accept  = I_VALID && O_READY;
    assign close   = closing[fill_ptr];
    assign TVALID  = full[drain_ptr];
    assign hs      = TVALID && TREADY;
    assign TDATA   = rd_data[drain_ptr];
    assign TLAST   = full[drain_ptr] && last[drain_ptr];
    assign TDEST   = '0;
    assign TID     = '0;

    // Route write/flush to the fill buffer and the handshake free to the drain buffer
    always_comb begin
        wr_en = '0;
        clear = '0;
        flush = '0;
        wr_en[fill_ptr]  = accept;
        flush[fill_ptr]  = force_close;
        clear[drain_ptr] = hs;
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        list_line_buf #(
            .DW (DW),
            .FS (FS)
        ) u_buf (
            .CLK     (ACLK),
            .RESET_N (ARESETn),
            .wr_en   (wr_en[g]),
            .wr_data (IN),
            .wr_last (I_LAST),
            .flush   (flush[g]),
            .clear   (clear[g]),
            .toggle  (toggle_q),
            .full    (full[g]),
            .last    (last[g]),
            .closing (closing[g]),
            .rd_data (rd_data[g])
        );
    end

    // Hold O_READY low until the first edge after reset release
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    // Closes always alternate buffers and so do drains, so each pointer is a single toggling bit
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            if (close) begin
                fill_ptr <= !fill_ptr;
            end
            if (hs) begin
                drain_ptr <= !drain_ptr;
                toggle_q  <= !toggle_q;
            end
        end
    end

`ifdef LIST_PACKER_TIMEOUT_EN
    localparam int unsigned TW = clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_q;
    logic          busy_q;

    // busy_q: fill buffer holds at least one element and has not closed
    assign force_close = busy_q && (idle_q == TW'(TIMEOUT)) && !accept;

    // Idle counter since the last accept; any accept restarts it
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            busy_q <= 1'b0;
            idle_q <= '0;
        end else if (accept) begin
            busy_q <= !close;
            idle_q <= '0;
        end else if (force_close) begin
            busy_q <= 1'b0;
            idle_q <= '0;
        end else if (busy_q) begin
            idle_q <= idle_q + TW'(1);
        end
    end
`else
    assign force_close = 1'b0;
`endif

endmodule

// File: tb/tb_list_packer.sv
// Self-checking bench for list_packer (DW=32, DBW=128 -> 3 payload words per beat).
// A queue-based packing model predicts every beat from the accepted element stream.
`timescale 1ns/1ps
module tb_list_packer;

    localparam int unsigned DW      = 32;
    localparam int unsigned DBW     = 128;
    localparam int unsigned FS      = DBW / DW;
    localparam int unsigned TIMEOUT = 8;

    typedef logic [DBW-1:0] beat_t;

    logic           ACLK    = 1'b0;
    logic           ARESETn = 1'b0;
    logic [DW-1:0]  IN      = '0;
    logic           I_VALID = 1'b0;
    logic           I_LAST  = 1'b0;
    logic           O_READY;
    logic [DBW-1:0] TDATA;
    logic           TVALID;
    logic           TREADY  = 1'b0;
    logic           TLAST;
    logic [3:0]     TDEST;
    logic [7:0]     TID;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;
    bit          rand_ready = 1'b0;

    // Reference model state
    beat_t         exp_q[$];
    logic          exp_last_q[$];
    logic [DW-1:0] cur[$];
    int unsigned   beats_made = 0;
    int unsigned   idle_cnt   = 0;
    logic          stall_prev = 1'b0;
    beat_t         stall_data;
    logic          stall_last;

    list_packer #(
        .DW      (DW),
        .DBW     (DBW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .IN      (IN),
        .I_VALID (I_VALID),
        .I_LAST  (I_LAST),
        .O_READY (O_READY),
        .TDATA   (TDATA),
        .TVALID  (TVALID),
        .TREADY  (TREADY),
        .TLAST   (TLAST),
        .TDEST   (TDEST),
        .TID     (TID)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc++;

    task automatic check(input string tag, input logic [DBW-1:0] obs, input logic [DBW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // A line becomes a beat: header = beat parity + 256*count, payload in order, rest zero
    function automatic void close_line(input logic lst);
        beat_t b;
        b = '0;
        b[31:0] = 32'((beats_made % 2) + cur.size() * 256);
        foreach (cur[i]) b[(i + 1) * DW +: DW] = cur[i];
        exp_q.push_back(b);
        exp_last_q.push_back(lst);
        beats_made++;
        cur.delete();
    endfunction

    // Monitor: model update on accepts, beat comparison on handshakes, stall stability
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            exp_q.delete();
            exp_last_q.delete();
            cur.delete();
            beats_made = 0;
            idle_cnt   = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_tvalid", TVALID, 1);
                check("stall_tdata", TDATA, stall_data);
                check("stall_tlast", TLAST, stall_last);
            end
            stall_prev = TVALID && !TREADY;
            stall_data = TDATA;
            stall_last = TLAST;
            if (TVALID && TREADY) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", TVALID, 0);
                end else begin
                    check("beat_data", TDATA, exp_q.pop_front());
                    check("beat_last", TLAST, exp_last_q.pop_front());
                end
            end
            if (I_VALID && O_READY) begin
                cur.push_back(IN);
                idle_cnt = 0;
                if (I_LAST || cur.size() == FS - 1) close_line(I_LAST);
            end
`ifdef LIST_PACKER_TIMEOUT_EN
            else if (cur.size() > 0) begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT + 1) begin
                    close_line(1'b0);
                    idle_cnt = 0;
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
        if (rand_ready) TREADY = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int unsigned n;
        logic acc;
        n = 0;
        IN      = d;
        I_LAST  = l;
        I_VALID = 1'b1;
        forever begin
            @(negedge ACLK);
            acc = O_READY;
            tick();
            if (acc) break;
            n++;
            if (n > 200) begin
                check("send_ready_timeout", O_READY, 1);
                break;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !TVALID) break;
            tick();
        end
        check("drain_tvalid", TVALID, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        int unsigned t0;
        int k;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_oready", O_READY, 0);
        check("rst_tvalid", TVALID, 0);
        check("rst_tlast", TLAST, 0);
        check("rst_tdata", TDATA, 0);
        check("tdest_tid", {TDEST, TID}, 0);
        ARESETn = 1'b1;
        tick();
        check("oready_after_rst", O_READY, 1);

        // Full line A,B,C back to back
        TREADY = 1'b1;
        t0 = cyc;
        send(32'hA0A0_0001, 1'b0);
        send(32'hB0B0_0002, 1'b0);
        send(32'hC0C0_0003, 1'b0);
        I_VALID = 1'b0;
        check("burst_cycles", cyc - t0, 3);
        check("b1_tvalid", TVALID, 1);
        check("b1_hdr", TDATA[31:0], 32'h0000_0300);
        check("b1_payload", TDATA[127:32], {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001});
        check("b1_tlast", TLAST, 0);
        tick();
        check("b1_one_cycle", TVALID, 0);

        // Short list D,E closed by I_LAST
        send(32'hD0D0_0004, 1'b0);
        send(32'hE0E0_0005, 1'b1);
        I_VALID = 1'b0;
        check("b2_tvalid", TVALID, 1);
        check("b2_hdr", TDATA[31:0], 32'h0000_0201);
        check("b2_payload", TDATA[95:32], {32'hE0E0_0005, 32'hD0D0_0004});
        check("b2_word3", TDATA[127:96], 0);
        check("b2_tlast", TLAST, 1);
        tick();
        check("b2_one_cycle", TVALID, 0);

        // Backpressure: both buffers fill, O_READY drops, then drain in order
        TREADY = 1'b0;
        for (int i = 0; i < 6; i++) send(32'h0000_0100 + 32'(i), 1'b0);
        I_VALID = 1'b0;
        check("full_oready", O_READY, 0);
        check("full_hdr", TDATA[31:0], 32'h0000_0300);
        repeat (4) tick();
        check("full_oready_hold", O_READY, 0);
        TREADY = 1'b1;
        for (int i = 6; i < 9; i++) send(32'h0000_0100 + 32'(i), 1'b0);
        I_VALID = 1'b0;
        wait_drain();

        // Random backpressure and input gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            I_VALID = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            send($urandom, (i == 63) ? 1'b1 : ($urandom_range(0, 7) == 0));
        end
        I_VALID = 1'b0;
        rand_ready = 1'b0;
        @(posedge ACLK);
        #2;
        TREADY = 1'b1;
        wait_drain();

        // Reset mid-operation with one beat pending and a partial line
        TREADY = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h0000_0500 + 32'(i), 1'b0);
        I_VALID = 1'b0;
        check("pre_rst_tvalid", TVALID, 1);
        ARESETn = 1'b0;
        #1;
        check("mid_rst_tvalid", TVALID, 0);
        check("mid_rst_oready", O_READY, 0);
        tick();
        ARESETn = 1'b1;
        tick();
        TREADY = 1'b1;
        for (int i = 0; i < 3; i++) send(32'h0000_0700 + 32'(i), 1'b0);
        I_VALID = 1'b0;
        check("post_rst_hdr", TDATA[31:0], 32'h0000_0300);
        check("post_rst_word1", TDATA[63:32], 32'h0000_0700);
        wait_drain();

`ifdef LIST_PACKER_TIMEOUT_EN
        // Idle flush of a one-element line
        send(32'h0000_ABCD, 1'b0);
        I_VALID = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(posedge ACLK);
            #1;
            if (TVALID) break;
        end
        check("tmo_latency", 32'(k), 9);
        check("tmo_hdr", TDATA[31:0], 32'h0000_0101);
        check("tmo_tlast", TLAST, 0);
        wait_drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion, required finish before 1ms");
        $fatal(1);
    end

endmodule

// File: doc/list_packer.md
Name: list_packer

Overview:
- Transmit-side counterpart of the list cache. Accepts a stream of DW-bit list elements from a HoP module over valid/ready and packs them into DBW-bit AXI4-Stream beats for the PL→PS/DMA direction.
- Word 0 of every beat is a header: bit 0 is the sequence toggle the list cache keys on, plus a payload element count. Words 1..FS-1 carry payload.
- Two line buffers are used, so one fills while the other drains.

Parameters:
- DW, 32, element width in bits (≥16).
- DBW, 4096, stream data width in bits; FS = DBW/DW words per beat; constraint 2 ≤ FS ≤ 256.
- TIMEOUT, 1024, idle cycles before a partial line is flushed (used only with the optional feature).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- IN  in  DW  element from HoP module
- I_VALID  in  1  IN valid
- I_LAST  in  1  IN is the final element of the list; forces a flush
- O_READY  out  1  packer can accept an element this cycle
- TDATA  out  DBW  packed beat; word k = TDATA[k*DW +: DW]
- TVALID  out  1  beat valid
- TREADY  in  1  sink ready
- TLAST  out  1  beat closes a list
- TDEST  out  4  tied 0
- TID  out  8  tied 0

Behaviour:
- One clock domain (ACLK). Reset is asynchronous, active-low (ARESETn).
- Reset values:
  - O_READY=0 during reset, 1 from the first cycle after deassertion.
  - TVALID=0, TLAST=0, TDATA=0.
  - Toggle=0, both buffers empty, fill pointer=buffer 0, write index=1.
- Element accept: an element is accepted when I_VALID&&O_READY. It is written to word[wr_idx] of the fill buffer, then wr_idx increments.
- Buffer close: the fill buffer closes in the same cycle it accepts either of these:
  - the element that makes wr_idx reach FS-1, or
  - any element with I_LAST=1.
- On close:
  - the buffer is marked full and records count = wr_idx (1..FS-1) and last = I_LAST;
  - the fill pointer swaps to the other buffer and wr_idx resets to 1.
- O_READY = the fill buffer is not full. It is registered-equivalent: when both buffers are full, O_READY drops the cycle after the second close. No combinational path from TREADY to O_READY.
- Drain: the drain pointer selects the oldest full buffer.
  - TVALID=1 from the cycle after that buffer closes (latency 1 from the accepting edge).
  - TDATA word 0 = header: bit0 = toggle, bits [8 +: clog2(FS)] = count, all other bits 0.
  - Words 1..count = payload; words count+1..FS-1 = 0.
  - TLAST = that buffer's last flag.
- AXI rules:
  - TDATA, TLAST, TVALID are held stable while TVALID && !TREADY.
  - TVALID never depends combinationally on TREADY.
- Handshake (TVALID&&TREADY): the buffer is freed, the toggle inverts, and the drain pointer advances.
  - The first beat after reset carries toggle=0, which matches the list cache reset line clock of 1. Subsequent beats alternate.
- Simultaneous close of one buffer and free of the other in the same cycle:
  - both take effect;
  - O_READY stays 1;
  - TVALID stays 1 next cycle, showing the newly closed buffer with the inverted toggle.
- Free of the only full buffer with no new close: TVALID=0 next cycle.
- Sustained throughput: one element per cycle while TREADY keeps up.
- Reset mid-operation: partial and full buffers are discarded and the toggle returns to 0. No beat is emitted for discarded data.

Optional Feature:
- Macro LIST_PACKER_TIMEOUT_EN.
- When defined:
  - a counter of clog2(TIMEOUT+1) bits counts cycles since the last accepted element while the fill buffer holds ≥1 element and is not full;
  - at TIMEOUT the buffer closes with last=0 and the count as is. The close cannot coincide with an accept, because any accept resets the counter.
- When undefined: partial lines close only via I_LAST, and the counter logic is absent.

Decomposition:
- Package list_pkg holds:
  - header bit positions (toggle bit 0, count offset 8);
  - count width function clog2(FS);
  - the FS localparam expression;
  - the count/last buffer-state struct.
  The list cache imports the same package.
- Sub-module list_line_buf: one FS×DW buffer with write index, full flag, count, last, write and clear ports, and header-inserted read-out. It is instantiated twice; list_packer holds the pointers, toggle, handshake and timeout.

Test Plan:
Bench uses DW=32, DBW=128 (FS=4, 3 payload words).
- Reset, then elements A,B,C with TREADY=1 → one beat, words {0x00000300 with bit0=0, A, B, C}, TLAST=0, TVALID exactly 1 cycle.
- Elements D,E with I_LAST on E → beat header count=2, toggle=1, word3=0, TLAST=1.
- TREADY=0, then 9 elements streamed → 2 beats held stable, O_READY=0 after the 6th accept. Raising TREADY drains both in order with toggles 0,1, and the remaining 3 elements follow as a third beat.
- TREADY toggled randomly for 64 elements → every header toggle alternates, no element lost or duplicated, TDATA stable during stalls.
- ARESETn pulsed mid-fill after 2 elements → TVALID=0 immediately, first post-reset beat has toggle 0 and only new data.
- With LIST_PACKER_TIMEOUT_EN and TIMEOUT=8, one element then idle → beat with count=1, TLAST=0, TVALID asserted 9 cycles after the accept.
